// File: rtl/mem_block_copier.sv
// ---------------------------------------------------------------------------
// mem_block_copier
//
// Bus initiator that copies `length` consecutive words from a source
// word-address to a destination word-address on a single-port data memory.
// Each word takes one read cycle followed by one write cycle. Memory read data
// is combinational. Memory writes commit on posedge clk while mem_write_read
// is high.
//
// Optional feature (macro MBC_CHECKSUM_EN):
//   When defined, a `checksum` output is added. It is the modulo-2^WIDTH sum
//   of every word read during the last accepted transfer. It clears on an
//   accepted start and holds after completion.
//   When undefined (the default build), there is no checksum port and no adder.
//
// Ports:
//   clk            in   1          system clock, all state on posedge
//   reset          in   1          asynchronous active-high reset
//   start          in   1          request pulse, sampled only in IDLE
//   src_addr       in   WIDTH      first source word-address
//   dst_addr       in   WIDTH      first destination word-address
//   length         in   LEN_WIDTH  number of words to copy
//   busy           out  1          high while reading/writing
//   done           out  1          one-cycle completion pulse
//   mem_address    out  WIDTH      memory word address
//   mem_write_read out  1          1 = write, 0 = read
//   mem_write_data out  WIDTH      memory write data
//   mem_read_data  in   WIDTH      memory read data (combinational)
//   checksum       out  WIDTH      only with MBC_CHECKSUM_EN
// ---------------------------------------------------------------------------
module mem_block_copier #(
  parameter int WIDTH     = 32,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     src_addr,
  input  logic [WIDTH-1:0]     dst_addr,
  input  logic [LEN_WIDTH-1:0] length,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     mem_address,
  output logic                 mem_write_read,
  output logic [WIDTH-1:0]     mem_write_data,
  input  logic [WIDTH-1:0]     mem_read_data
`ifdef MBC_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0]     checksum
`endif
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     src_reg, src_next;
  logic [WIDTH-1:0]     dst_reg, dst_next;
  logic [WIDTH-1:0]     buf_reg, buf_next;
  logic [LEN_WIDTH-1:0] len_reg, len_next;
  logic [LEN_WIDTH-1:0] idx_reg, idx_next;
  logic [WIDTH-1:0]     idx_ext;
`ifdef MBC_CHECKSUM_EN
  logic [WIDTH-1:0]     csum_reg, csum_next;
`endif

  // Word index widened to address width; the address sums wrap naturally.
  assign idx_ext = WIDTH'(idx_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      src_reg   <= '0;
      dst_reg   <= '0;
      buf_reg   <= '0;
      len_reg   <= '0;
      idx_reg   <= '0;
`ifdef MBC_CHECKSUM_EN
      csum_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      src_reg   <= src_next;
      dst_reg   <= dst_next;
      buf_reg   <= buf_next;
      len_reg   <= len_next;
      idx_reg   <= idx_next;
`ifdef MBC_CHECKSUM_EN
      csum_reg  <= csum_next;
`endif
    end
  end

  // Next-state and output decode. All outputs derive from registered state, so
  // an asynchronous reset forces the memory outputs low without a clock edge.
  always_comb begin
    state_next     = state_reg;
    src_next       = src_reg;
    dst_next       = dst_reg;
    buf_next       = buf_reg;
    len_next       = len_reg;
    idx_next       = idx_reg;
`ifdef MBC_CHECKSUM_EN
    csum_next      = csum_reg;
`endif
    busy           = 1'b0;
    done           = 1'b0;
    mem_address    = '0;
    mem_write_read = 1'b0;
    mem_write_data = '0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          src_next   = src_addr;
          dst_next   = dst_addr;
          len_next   = length;
          idx_next   = '0;
`ifdef MBC_CHECKSUM_EN
          csum_next  = '0;
`endif
          // A zero-length request completes without touching memory.
          state_next = (length == '0) ? DONE : READ;
        end
      end
      READ: begin
        busy        = 1'b1;
        mem_address = src_reg + idx_ext;
        buf_next    = mem_read_data;
`ifdef MBC_CHECKSUM_EN
        csum_next   = csum_reg + mem_read_data;
`endif
        state_next  = WRITE;
      end
      WRITE: begin
        busy           = 1'b1;
        mem_address    = dst_reg + idx_ext;
        mem_write_read = 1'b1;
        mem_write_data = buf_reg;
        if (idx_reg == len_reg - 1'b1) begin
          state_next = DONE;
        end else begin
          idx_next   = idx_reg + 1'b1;
          state_next = READ;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef MBC_CHECKSUM_EN
  assign checksum = csum_reg;
`endif

endmodule

// File: tb/tb_mem_block_copier.sv
`timescale 1ns/1ps
module tb_mem_block_copier;
  localparam int MEM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] length = '0;
  logic        busy, done, mem_write_read;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
`ifdef MBC_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  // Memory: low 10 address bits select a word, so wrapped addresses alias
  // consistently in both the memory and the reference image.
  logic [31:0] mem      [MEM_WORDS];
  logic [31:0] init_img [MEM_WORDS];
  logic [31:0] ref_mem  [MEM_WORDS];
  logic        init_mem = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_block_copier #(.WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .done(done),
    .mem_address(mem_address), .mem_write_read(mem_write_read),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
`ifdef MBC_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  assign mem_read_data = mem[mem_address[9:0]];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= init_img[i];
    end else if (mem_write_read) begin
      mem[mem_address[9:0]] <= mem_write_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: sequential forward word copy with running sum of words read.
  task automatic ref_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                          output logic [31:0] csum);
    logic [31:0] a, w;
    csum = '0;
    for (int i = 0; i < int'(n); i++) begin
      a = s + i;
      w = ref_mem[a[9:0]];
      csum = csum + w;
      a = d + i;
      ref_mem[a[9:0]] = w;
    end
  endtask

  task automatic compare_mem(input string name);
    int bad = 0;
    bit found = 0;
    for (int i = 0; i < MEM_WORDS; i++)
      if (!found && mem[i] !== ref_mem[i]) begin bad = i; found = 1; end
    check(name, mem[bad], ref_mem[bad]);
  endtask

  // Issues one start and watches 2n+4 cycles after the accepting edge.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                          input bit repulse, output int busy_n, output int done_c,
                          output int done_n, output int wr_n, output int addr_err);
    logic [31:0] exp_a;
    int rd_i, wr_i, total;
    busy_n = 0; done_c = -1; done_n = 0; wr_n = 0; addr_err = 0; rd_i = 0; wr_i = 0;
    total = 2 * int'(n) + 4;
    @(negedge clk);
    src_addr = s; dst_addr = d; length = n; start = 1'b1;
    @(posedge clk);
    #1;
    start = repulse;
    src_addr = $urandom; dst_addr = $urandom; length = 16'($urandom);
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_c < 0) done_c = c;
      end
      if (busy && !mem_write_read) begin
        exp_a = s + rd_i;
        if (mem_address !== exp_a) addr_err++;
        rd_i++;
      end
      if (mem_write_read) begin
        exp_a = d + wr_i;
        if (mem_address !== exp_a) addr_err++;
        wr_n++;
        wr_i++;
      end
      start = repulse && (c <= 2 * int'(n) + 1);
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    bit          repulse;
    int          exp_busy;
    int          exp_done_c;
    int          exp_writes;
    bit          has_csum;
    logic [31:0] exp_csum;
  } vec_t;

  vec_t        vecs [7];
  int          busy_n, done_c, done_n, wr_n, addr_err, seen_done;
  logic [31:0] csum_exp;
  logic [31:0] rs, rd;
  logic [15:0] rn;

  task automatic check_run(input string tag, input logic [31:0] s, input logic [31:0] d,
                           input logic [15:0] n, input bit repulse,
                           input int exp_busy, input int exp_done_c, input int exp_writes);
    run_copy(s, d, n, repulse, busy_n, done_c, done_n, wr_n, addr_err);
    ref_copy(s, d, n, csum_exp);
    check({tag, "_busy_cycles"}, busy_n, exp_busy);
    check({tag, "_done_cycle"}, done_c, exp_done_c);
    check({tag, "_done_pulses"}, done_n, 1);
    check({tag, "_writes"}, wr_n, exp_writes);
    check({tag, "_addr_errors"}, addr_err, 0);
    compare_mem({tag, "_mem_image"});
`ifdef MBC_CHECKSUM_EN
    check({tag, "_checksum"}, checksum, csum_exp);
`endif
    $display("%s src=0x%08h dst=0x%08h len=%0d busy=%0d done_cycle=%0d writes=%0d",
             tag, s, d, n, busy_n, done_c, wr_n);
  endtask

  initial begin
    vecs[0] = '{32'h10,       32'h40,  16'd4, 1'b0, 8,  9,  4, 1'b0, 32'h0};
    vecs[1] = '{32'h5,        32'h6,   16'd0, 1'b0, 0,  1,  0, 1'b0, 32'h0};
    vecs[2] = '{32'h20,       32'h60,  16'd3, 1'b1, 6,  7,  3, 1'b0, 32'h0};
    vecs[3] = '{32'hFFFF_FFFF, 32'h80, 16'd2, 1'b0, 4,  5,  2, 1'b0, 32'h0};
    vecs[4] = '{32'h100,      32'h140, 16'd4, 1'b0, 8,  9,  4, 1'b1, 32'h5};
    vecs[5] = '{32'h30,       32'h30,  16'd3, 1'b0, 6,  7,  3, 1'b0, 32'h0};
    vecs[6] = '{32'h300,      32'h302, 16'd5, 1'b0, 10, 11, 5, 1'b0, 32'h0};

    for (int i = 0; i < MEM_WORDS; i++) init_img[i] = $urandom;
    init_img[32'h10] = 32'hAAAA_0001;
    init_img[32'h11] = 32'hBBBB_0002;
    init_img[32'h12] = 32'hCCCC_0003;
    init_img[32'h13] = 32'hDDDD_0004;
    init_img[32'h100] = 32'h1;
    init_img[32'h101] = 32'h2;
    init_img[32'h102] = 32'h3;
    init_img[32'h103] = 32'hFFFF_FFFF;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_img[i];

    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_mem_address", mem_address, 0);
    check("reset_write_read", mem_write_read, 0);
    check("reset_write_data", mem_write_data, 0);
`ifdef MBC_CHECKSUM_EN
    check("reset_checksum", checksum, 0);
`endif
    init_mem = 1'b1;
    @(posedge clk);
    #1 init_mem = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    for (int t = 0; t < 7; t++) begin
      check_run($sformatf("vec%0d", t), vecs[t].src, vecs[t].dst, vecs[t].len,
                vecs[t].repulse, vecs[t].exp_busy, vecs[t].exp_done_c, vecs[t].exp_writes);
`ifdef MBC_CHECKSUM_EN
      if (vecs[t].has_csum) check($sformatf("vec%0d_checksum_const", t), checksum, vecs[t].exp_csum);
`endif
    end

    // Abort during the write of word 2 of a 4-word copy.
    @(negedge clk);
    src_addr = 32'h200; dst_addr = 32'h240; length = 16'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 6; c++) @(negedge clk);
    check("abort_pre_write_read", mem_write_read, 1);
    check("abort_pre_address", mem_address, 32'h242);
    reset = 1'b1;
    #1;
    check("abort_write_read", mem_write_read, 0);
    check("abort_busy", busy, 0);
    check("abort_address", mem_address, 0);
`ifdef MBC_CHECKSUM_EN
    check("abort_checksum", checksum, 0);
`endif
    @(negedge clk);
    reset = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    check("abort_no_done_or_busy", seen_done, 0);
    ref_copy(32'h200, 32'h240, 16'd2, csum_exp);
    compare_mem("abort_mem_image");
    $display("abort src=0x00000200 dst=0x00000240 len=4 reset_in_word=2 activity_after=%0d", seen_done);

    check_run("after_abort", 32'h10, 32'h48, 16'd4, 1'b0, 8, 9, 4);

    for (int r = 0; r < 8; r++) begin
      rs = $urandom;
      rd = $urandom;
      rn = 16'($urandom_range(0, 12));
      check_run($sformatf("rand%0d", r), rs, rd, rn, r[0], 2 * int'(rn), 2 * int'(rn) + 1, int'(rn));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
